// File: rtl/n2t_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the FSM state encoding, default sizes and the one-hot helper.
package n2t_arb_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 16;
    localparam int MAX_N     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/my_rr_pick.sv
// Round-robin pick: first requester after 'last', scanning upward modulo N.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// 'any' is low and 'idx' is zero when no request is pending.
module my_rr_pick
    import n2t_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        int p;
        any = 1'b0;
        idx = '0;
        p   = 0;
        for (int k = N; k >= 1; k--) begin
            p = (int'(last) + k) % N;
            if (req[IW'(p)]) begin
                any = 1'b1;
                idx = IW'(p);
            end
        end
    end

endmodule

// File: rtl/my_mux_16_arbiter.sv
// Round-robin arbiter muxing N requester words onto one valid/ready output bus.
// Latency: req -> out_valid 1 cycle; one IDLE cycle after every transfer or abort.
// Backpressure: grant is held while out_ready is low; requester dropping req aborts.
module my_mux_16_arbiter
    import n2t_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_count
);

    localparam int IW = $clog2(N);

    state_t         state, state_nxt;
    logic [IW-1:0]  gidx, gidx_nxt;
    logic [IW-1:0]  last, last_nxt;
    logic [N-1:0]   grant_nxt;
    logic [N-1:0]   ack_c;
    logic [15:0]    count_nxt;
    logic           pick_any;
    logic [IW-1:0]  pick_idx;
    logic [WIDTH-1:0] sel;

    my_rr_pick #(.N(N)) u_pick (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            gidx       <= '0;
            last       <= IW'(N - 1);
            xfer_count <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            gidx       <= gidx_nxt;
            last       <= last_nxt;
            xfer_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        last_nxt  = last;
        count_nxt = xfer_count;
        ack_c     = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    gidx_nxt  = pick_idx;
                    grant_nxt = N'(onehot(3'(pick_idx)));
                end
            end
            BUSY: begin
                // Abort takes priority over acceptance when req drops.
                if (!req[gidx]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (out_ready) begin
                    ack_c     = grant;
                    last_nxt  = gidx;
                    count_nxt = xfer_count + 16'd1;
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Select from the registered grant index so req never reaches out combinationally.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx == IW'(i)) begin
                sel = data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (state == BUSY);
    assign out       = out_valid ? sel : '0;
    assign ack       = reset ? '0 : ack_c;

endmodule

// File: tb/tb_my_mux_16_arbiter.sv
// Directed bench for the round-robin arbiter and its pick sub-module.
module tb_my_mux_16_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_count;

    logic [3:0]  pr_req;
    logic [1:0]  pr_last;
    logic        pr_any;
    logic [1:0]  pr_idx;

    int tests_run;
    int tests_failed;

    my_mux_16_arbiter #(.N(4), .WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .ack        (ack),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    my_rr_pick #(.N(4)) u_pick_tb (
        .req  (pr_req),
        .last (pr_last),
        .any  (pr_any),
        .idx  (pr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_rr_pick;
        logic [3:0] v_req  [6] = '{4'b0000, 4'b1111, 4'b1111, 4'b0001, 4'b1010, 4'b0110};
        logic [1:0] v_last [6] = '{2'd1,    2'd3,    2'd0,    2'd0,    2'd1,    2'd3};
        logic       v_any  [6] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
        logic [1:0] v_idx  [6] = '{2'd0,    2'd0,    2'd1,    2'd0,    2'd3,    2'd1};
        for (int i = 0; i < 6; i++) begin
            pr_req  = v_req[i];
            pr_last = v_last[i];
            #1;
            tests_run++;
            if (pr_any !== v_any[i] || pr_idx !== v_idx[i]) begin
                tests_failed++;
                $display("FAIL rr_pick[%0d] got any=%b idx=%0d exp any=%b idx=%0d",
                         i, pr_any, pr_idx, v_any[i], v_idx[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; data = '0; out_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        #1;
        tests_run++;
        if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (out !== 16'h0000) begin tests_failed++; $display("FAIL reset_out got=%h exp=0000", out); end
        tests_run++;
        if (xfer_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        tests_run++;
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    endtask

    task automatic test_single;
        data = {16'h0000, 16'hCCCC, 16'h0000, 16'h0000};
        out_ready = 1'b1;
        req = 4'b0100;
        tick; #1;
        tests_run++;
        if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant got=%b exp=0100", grant); end
        tests_run++;
        if (out !== 16'hCCCC || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL single_out got=%h/%b exp=cccc/1", out, out_valid);
        end
        tests_run++;
        if (ack !== 4'b0100) begin tests_failed++; $display("FAIL single_ack got=%b exp=0100", ack); end
        tick;
        req = 4'b0000;
        #1;
        tests_run++;
        if (xfer_count !== 16'd1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_idle got=%b/%b exp=0000/0", grant, out_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] exp_o [5] = '{16'h02B2, 16'h02B3, 16'h02B4, 16'h02B5, 16'h02B2};
        reset = 1'b1; req = '0;
        tick;
        reset = 1'b0;
        data = {16'h02B5, 16'h02B4, 16'h02B3, 16'h02B2};
        out_ready = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            req = 4'b1111;
            #1;
            tests_run++;
            if (grant !== exp_g[k] || out !== exp_o[k] || ack !== exp_g[k]) begin
                tests_failed++;
                $display("FAIL rr_xfer[%0d] got grant=%b out=%h ack=%b exp grant=%b out=%h ack=%b",
                         k, grant, out, ack, exp_g[k], exp_o[k], exp_g[k]);
            end
            tick;
            req = 4'b1111 & ~exp_g[k];
            #1;
            tests_run++;
            if (ack !== 4'b0000 || out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL rr_gap[%0d] got ack=%b valid=%b exp 0000/0", k, ack, out_valid);
            end
        end
        tests_run++;
        if (xfer_count !== 16'd5) begin tests_failed++; $display("FAIL rr_count got=%0d exp=5", xfer_count); end
        req = 4'b0000;
    endtask

    task automatic test_backpressure;
        tick;
        data = {16'h0000, 16'h0000, 16'hB0B1, 16'hA0A0};
        out_ready = 1'b0;
        req = 4'b0010;
        for (int s = 0; s < 4; s++) begin
            tick;
            if (s == 1) req = 4'b0011;
            #1;
            tests_run++;
            if (grant !== 4'b0010 || out !== 16'hB0B1 || ack !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_stall[%0d] got grant=%b out=%h ack=%b exp 0010/b0b1/0000", s, grant, out, ack);
            end
        end
        tick;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (ack !== 4'b0010 || out !== 16'hB0B1) begin
            tests_failed++; $display("FAIL bp_accept got ack=%b out=%h exp 0010/b0b1", ack, out);
        end
        tick;
        req = 4'b0001;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_gap got grant=%b valid=%b exp 0000/0", grant, out_valid);
        end
        tick; #1;
        tests_run++;
        if (grant !== 4'b0001 || ack !== 4'b0001 || out !== 16'hA0A0) begin
            tests_failed++; $display("FAIL bp_next got grant=%b ack=%b out=%h exp 0001/0001/a0a0", grant, ack, out);
        end
        tick;
        req = 4'b0000;
        #1;
        tests_run++;
        if (xfer_count !== 16'd7) begin tests_failed++; $display("FAIL bp_count got=%0d exp=7", xfer_count); end
    endtask

    task automatic test_abort;
        data = {16'hD3D3, 16'h0000, 16'h1111, 16'h0000};
        out_ready = 1'b0;
        req = 4'b1000;
        tick; tick; #1;
        tests_run++;
        if (grant !== 4'b1000 || out !== 16'hD3D3) begin
            tests_failed++; $display("FAIL abort_grant got grant=%b out=%h exp 1000/d3d3", grant, out);
        end
        req = 4'b0000;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL abort_ack got=%b exp=0000", ack); end
        tick; #1;
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || xfer_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL abort_idle got grant=%b valid=%b count=%0d exp 0000/0/7", grant, out_valid, xfer_count);
        end
        req = 4'b1111;
        tick; #1;
        tests_run++;
        if (grant !== 4'b0010 || out !== 16'h1111) begin
            tests_failed++; $display("FAIL abort_rearb got grant=%b out=%h exp 0010/1111", grant, out);
        end
        tick;
        req = 4'b0000;
        #1;
        tests_run++;
        if (xfer_count !== 16'd8) begin tests_failed++; $display("FAIL abort_count got=%0d exp=8", xfer_count); end
    endtask

    task automatic test_reset_mid;
        data = {16'h0000, 16'h5555, 16'h0000, 16'h7777};
        out_ready = 1'b0;
        req = 4'b0100;
        tick; tick;
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_ack got=%b exp=0000", ack); end
        tick;
        reset = 1'b0;
        req = 4'b0000;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || out_valid !== 1'b0 || out !== 16'h0000 || xfer_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_state got grant=%b valid=%b out=%h count=%0d exp 0000/0/0000/0",
                     grant, out_valid, out, xfer_count);
        end
        req = 4'b1111;
        tick; #1;
        tests_run++;
        if (grant !== 4'b0001 || out !== 16'h7777) begin
            tests_failed++; $display("FAIL rstmid_prio got grant=%b out=%h exp 0001/7777", grant, out);
        end
        tick;
        req = 4'b0000;
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        req = 4'b0000;
        force dut.xfer_count = 16'hFFFF;
        tick;
        release dut.xfer_count;
        tick; #1;
        tests_run++;
        if (xfer_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_preload got=%h exp=ffff", xfer_count); end
        req = 4'b0010;
        tick; tick;
        req = 4'b0000;
        #1;
        tests_run++;
        if (xfer_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_count got=%h exp=0000", xfer_count); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1; req = '0; data = '0; out_ready = 1'b0;
        pr_req = '0; pr_last = '0;
        test_rr_pick();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/my_mux_16_arbiter.md
Name: my_mux_16_arbiter

Overview:
- Round-robin arbiter sharing one 16-bit output bus among N requesters.
- Internally selects the granted requester's data through a my_mux_16-style selection tree.
- Presents the selected word downstream with a valid/ready handshake.
- Pulses a per-requester ack on acceptance and counts completed transfers; sits between register-file/ALU sources and a shared bus consumer.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 16, data width per requester.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request; data must be held stable while req is high.
- data  input  N*WIDTH  flattened requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- grant  output  N  one-hot registered grant; all zero when idle.
- ack  output  N  one-hot, combinational; high for the single cycle the granted word is accepted.
- out  output  WIDTH  selected data; 0 when out_valid is low.
- out_valid  output  1  high while a granted word is presented.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- xfer_count  output  16  completed-transfer counter; wraps 0xFFFF -> 0x0000.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, grant 0, out_valid 0, out 0, ack 0, xfer_count 0, last pointer N-1 (requester 0 has first priority after reset).
- Reset asserted mid-transfer: abandon immediately, no ack, all outputs to reset values on the next edge.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, pick the first requesting index scanning last+1, last+2, ... mod N.
  - Register grant = onehot(pick), go to BUSY. Latency req -> out_valid is 1 cycle.
  - If req == 0, stay in IDLE.
- BUSY:
  - out_valid = 1; out = data slice of the granted index, from the registered grant index (no combinational path from req to out).
  - out_ready && req[g]: ack[g] = 1 this cycle; last <= g; xfer_count += 1; grant <= 0; go to IDLE.
  - req[g] drops before acceptance: abort. Next state IDLE, grant <= 0, no ack, last and xfer_count unchanged.
  - If req[g] low and out_ready high in the same cycle, abort wins: no ack.
  - Otherwise hold state. Grant is sticky and not preempted by other requests.
- Every transfer is followed by one IDLE cycle, so peak throughput is one word per 2 cycles. This guarantees the acked requester has dropped req before re-arbitration.
- Invariants: grant and ack each at most one-hot; ack only ever a subset of grant; out_valid == (state == BUSY).
- data changing while granted is a requester protocol violation; out follows data combinationally, so there is no defined capture.

Decomposition:
- Package n2t_arb_pkg:
  - state_t enum {IDLE, BUSY}.
  - Default N and WIDTH constants.
  - A function onehot(idx).
- Sub-module my_rr_pick:
  - Purely combinational.
  - Inputs: req[N], last[$clog2(N)]. Outputs: any, idx.
  - Unit-tested alone.
- Output selection is an N-way mux of WIDTH-bit slices.

Test Plan:
- Reset, then req = 0 for 5 cycles -> grant 0, out_valid 0, out 0x0000, xfer_count 0.
- Single requester: req = 0b0100, data[2] = 0xCCCC, out_ready = 1 -> next cycle grant 0b0100, out 0xCCCC, ack 0b0100 in that cycle; xfer_count 1 afterward.
- Round-robin fairness: req = 0b1111 held, out_ready = 1, data[i] = 0x02B2 + i, ack honoured by dropping and re-raising req -> grant order 0, 1, 2, 3, 0. Acks every 2nd cycle; out sequence 0x02B2, 0x02B3, 0x02B4, 0x02B5.
- Backpressure: grant on requester 1 with out_ready = 0 for 4 cycles, then 1 -> out stable at data[1] for 5 cycles. A new req on 0 during the stall is ignored until after the ack.
- Abort: granted requester 3 drops req while out_ready = 0 -> next cycle IDLE, no ack, xfer_count unchanged. The next arbitration still starts after the previous last pointer.
- Reset mid-BUSY with out_ready = 1 asserted in the same cycle -> no ack; all outputs return to reset values next edge. xfer_count wrap: preload via 65535 transfers, one more -> 0x0000.
